// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller beside the ID/EX register: load-use, MULT, fwd.
// Optional macro HAZARD_FWD_EN enables EX forwarding; otherwise it stalls.
module pipe_hazard_ctrl #(
    parameter int MUL_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [4:0] id_rs_addr,
    input  logic [4:0] id_rt_addr,
    input  logic       id_uses_rt,
    input  logic [1:0] id_alu_op,
    input  logic [5:0] id_funct,
    input  logic       ex_reg_write,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd_addr,
    input  logic       mem_reg_write,
    input  logic [4:0] mem_rd_addr,
    output logic       id_stall,
    output logic       idex_en,
    output logic       idex_flush,
    output logic       exmem_flush,
    output logic [1:0] fwd_rs_sel,
    output logic [1:0] fwd_rt_sel,
    output logic       mul_busy
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [3:0] CNT_INIT = 4'(MUL_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] rs_sel_q, rs_sel_d;
    logic [1:0] rt_sel_q, rt_sel_d;

    logic ex_rs, ex_rt, mem_rs, mem_rt;
    logic load_use, mul_issue, hazard;

    function automatic logic hit(input logic [4:0] a, input logic we,
                                 input logic [4:0] rd);
        return we && (rd != 5'd0) && (rd == a);
    endfunction

    function automatic logic [1:0] pick(input logic ex_m, input logic mem_m);
        if (ex_m)
            return 2'b01;
        else if (mem_m)
            return 2'b10;
        return 2'b00;
    endfunction

    assign ex_rs  = hit(id_rs_addr, ex_reg_write, ex_rd_addr);
    assign ex_rt  = hit(id_rt_addr, ex_reg_write, ex_rd_addr);
    assign mem_rs = hit(id_rs_addr, mem_reg_write, mem_rd_addr);
    assign mem_rt = hit(id_rt_addr, mem_reg_write, mem_rd_addr);

    assign load_use  = id_valid && ex_mem_read &&
                       (ex_rs || (id_uses_rt && ex_rt));
    assign mul_issue = id_valid && (id_alu_op == 2'b10) &&
                       (id_funct == 6'h18);

`ifdef HAZARD_FWD_EN
    assign hazard = load_use;
`else
    // Without forwarding any in-flight producer must drain to WB first.
    assign hazard = load_use ||
                    (id_valid && (ex_rs || mem_rs ||
                     (id_uses_rt && (ex_rt || mem_rt))));
`endif

    // State, counter and forwarding-select registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            rs_sel_q <= 2'b00;
            rt_sel_q <= 2'b00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rs_sel_q <= rs_sel_d;
            rt_sel_q <= rt_sel_d;
        end
    end

    // Next state and stall/flush outputs; hazards ignored while BUSY.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        id_stall    = 1'b0;
        idex_en     = 1'b1;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (hazard) begin
                    id_stall   = 1'b1;
                    idex_flush = 1'b1;
                end else if (mul_issue) begin
                    state_d = BUSY;
                    cnt_d   = CNT_INIT;
                end
            end
            BUSY: begin
                id_stall    = 1'b1;
                idex_en     = 1'b0;
                exmem_flush = 1'b1;
                cnt_d       = cnt_q - 4'd1;
                if (cnt_q == 4'd1)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Selects load on a normal ID/EX load, clear on a bubble, else hold.
    always_comb begin
        rs_sel_d = rs_sel_q;
        rt_sel_d = rt_sel_q;
        if (idex_en) begin
            if (idex_flush) begin
                rs_sel_d = 2'b00;
                rt_sel_d = 2'b00;
            end else begin
`ifdef HAZARD_FWD_EN
                rs_sel_d = pick(ex_rs, mem_rs);
                rt_sel_d = pick(ex_rt, mem_rt);
`else
                rs_sel_d = 2'b00;
                rt_sel_d = 2'b00;
`endif
            end
        end
    end

    assign fwd_rs_sel = rs_sel_q;
    assign fwd_rt_sel = rt_sel_q;
    assign mul_busy   = (state_q == BUSY);

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage integer pipeline. It sits beside the ID/EX stage register and decides each cycle whether that register loads, holds or takes a bubble. It detects load-use hazards and sequences a multi-cycle MULT through EX. It also produces registered forwarding selects for the Rs/Rt operand muxes in EX.

## Interface
- MUL_CYCLES, 4, total EX-stage occupancy of MULT in cycles; legal range 2..16.
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  a real instruction is present in ID.
- id_rs_addr  in  5  Rs of ID instruction.
- id_rt_addr  in  5  Rt of ID instruction.
- id_uses_rt  in  1  ID instruction reads Rt.
- id_alu_op  in  2  ALUOp of ID instruction.
- id_funct  in  6  Funct of ID instruction.
- ex_reg_write  in  1  EX instruction writes a register.
- ex_mem_read  in  1  EX instruction is a load.
- ex_rd_addr  in  5  EX destination.
- mem_reg_write  in  1  MEM instruction writes a register.
- mem_rd_addr  in  5  MEM destination.
- id_stall  out  1  hold PC and IF/ID.
- idex_en  out  1  ID/EX load enable; 0 = hold contents.
- idex_flush  out  1  ID/EX loads a bubble (RegWrite=0, ALUOp=0).
- exmem_flush  out  1  EX/MEM loads a bubble.
- fwd_rs_sel  out  2  Rs source in EX: 00 regfile, 01 EX/MEM, 10 MEM/WB.
- fwd_rt_sel  out  2  Rt source in EX; same encoding.
- mul_busy  out  1  FSM in BUSY.

## Operation
- A hazard match needs a nonzero address and reg_write=1 on the producer. Register $0 never matches.
- MULT issue condition: id_valid, id_alu_op==2'b10 and id_funct==6'h18.
- Load-use condition: id_valid, ex_mem_read, and ex_rd_addr equals Rs, or equals Rt with id_uses_rt=1.
- The FSM has two states, IDLE and BUSY, plus a down counter cnt of 4 bits.
- IDLE, load-use true: id_stall=1, idex_en=1, idex_flush=1. This inserts one bubble.
- IDLE, no hazard: idex_en=1, all stall and flush outputs 0.
- IDLE, MULT issues with no load-use hazard: ID/EX loads normally. Next state is BUSY, and cnt loads MUL_CYCLES-1.
- BUSY: id_stall=1, idex_en=0 and exmem_flush=1. cnt decrements each cycle, and the FSM returns to IDLE on the edge where cnt goes 1→0.
- In BUSY, hazard detection is suppressed. The ID instruction is re-evaluated in the first IDLE cycle.
- Load-use has priority over MULT issue. A dependent MULT stalls first and issues after the bubble.
- Forwarding selects are computed from the ID addresses and registered on each edge where idex_en=1 and idex_flush=0.
  - Sel is 01 if the address matches ex_rd_addr; else 10 if it matches mem_rd_addr; else 00.
  - The EX match wins, so the youngest producer is selected.
- On an edge with idex_flush=1, the forwarding selects load 00.
- During a hold, the forwarding selects keep their value. They are valid only in the first EX cycle, and the multiplier latches its operands in that cycle.

## Timing
- Reset values: state IDLE, cnt 0, fwd_rs_sel/fwd_rt_sel 00, mul_busy 0.
- All outputs other than the registered selects and mul_busy are combinational from state and inputs.
- Load-use costs exactly 1 stall cycle. After the bubble, the load is in WB and the registered sel gives 10.
- MULT occupies EX for MUL_CYCLES cycles. id_stall is high for MUL_CYCLES-1 cycles, starting the cycle after issue.
- Back-to-back MULT: the second MULT issues in the first IDLE cycle, with no extra gap.
- Reset asserted mid-BUSY: the block returns immediately to IDLE with cnt 0. After reset releases, stall outputs are 0.

## Configuration
- HAZARD_FWD_EN defined: forwarding as described.
- HAZARD_FWD_EN undefined: fwd selects are tied to 00. Any Rs/Rt match against an EX or MEM producer is treated like load-use: id_stall=1 and idex_flush=1, repeating until the producer reaches WB. The register file provides write-before-read. MULT sequencing is unchanged.

## Test plan
- Load-use: lw $2 in EX, ID add uses Rs=$2 → one cycle with id_stall=1 and idex_flush=1, then issue with fwd_rs_sel=10.
- ALU to ALU: ex_rd=$3 with reg_write, ID Rt=$3, id_uses_rt=1 → no stall, fwd_rt_sel=01 after the edge. Same case with mem_rd=$3 as well → 01 (EX wins).
- $0 destination: ex_rd=0 with ex_mem_read=1, ID Rs=0 → no stall, sel 00.
- MULT with MUL_CYCLES=4 → mul_busy high for 3 cycles, id_stall/exmem_flush high for 3 cycles, idex_en low for 3 cycles, then IDLE.
- Reset asserted during the second BUSY cycle → mul_busy=0 and id_stall=0 immediately, sels 00.
- HAZARD_FWD_EN undefined: ALU producer in EX with a dependent consumer in ID → 2 stall cycles, then issue with sel 00.
